branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences control-flow redirection for the 5-stage pipeline. It consumes the EX-stage branch decision (branch taken or JAL), drives the fetch PC mux and the IF/ID and ID/EX flush lines, and holds a redirect until instruction fetch can accept it. It arbitrates between redirect-flush and load-use stall requests, and keeps wrap-around branch performance counters. It sits between the EX-stage branch comparator, the hazard unit and the fetch stage.

## Interface
- `XLEN`, 32, PC/target width
- `CNT_W`, 32, performance counter width
- `i_clk`  in  1  clock, all state on rising edge
- `i_rst_n`  in  1  synchronous, active-low reset
- `i_ex_valid`  in  1  EX stage holds a real (non-bubble) instruction
- `i_ex_is_branch`  in  1  EX instruction is a conditional branch
- `i_ex_is_jal`  in  1  EX instruction is JAL/JALR
- `i_ex_taken`  in  1  branch-taken decision from the comparator (includes JAL)
- `i_ex_target`  in  XLEN  computed target address
- `i_hz_stall`  in  1  load-use stall request from the hazard unit
- `i_imem_ready`  in  1  fetch can accept a new PC this cycle
- `o_pc_sel`  out  1  1 = fetch uses `o_pc_redirect`, 0 = PC+4
- `o_pc_redirect`  out  XLEN  redirect address
- `o_flush_ifid`, `o_flush_idex`  out  1 each  squash wrong-path instructions
- `o_stall_ifid`  out  1  hold the PC and IF/ID registers
- `o_redirect_pending`  out  1  FSM is in HOLD
- `o_misaligned`  out  1  one-cycle pulse: accepted target has `[1:0] != 0`
- `o_br_count`, `o_taken_count`  out  CNT_W each  events retired through EX

## Operation
- The FSM has two states: IDLE and HOLD.
- **Trigger:** `redirect_req = i_ex_valid & i_ex_taken`, evaluated in IDLE only.
- **IDLE with `redirect_req`:**
  - Combinationally assert `o_pc_sel=1`, `o_pc_redirect=i_ex_target`, `o_flush_ifid=1` and `o_flush_idex=1`.
  - If `i_imem_ready=1`, stay in IDLE.
  - Otherwise register the target into `tgt_q` and enter HOLD.
- **HOLD:**
  - `o_pc_sel=1`, `o_pc_redirect=tgt_q`, `o_flush_ifid=1`, `o_flush_idex=1`, `o_redirect_pending=1`.
  - EX inputs are ignored because EX holds squashed bubbles.
  - Exit to IDLE on the first cycle with `i_imem_ready=1`; that cycle still drives `tgt_q`.
- **Stall vs flush:**
  - `o_stall_ifid = i_hz_stall & ~o_flush_ifid`.
  - Flush always wins; a load-use stall coincident with a redirect is dropped because the dependent instruction is on the wrong path.
- **Misalignment:**
  - `o_misaligned` is registered and pulses 1 cycle after IDLE accepts a redirect whose `i_ex_target[1:0] != 0`.
  - The redirect still proceeds; trap handling belongs elsewhere.
- **Counters:**
  - `o_br_count` increments when `i_ex_valid & (i_ex_is_branch | i_ex_is_jal)` in IDLE.
  - `o_taken_count` increments when `redirect_req` in IDLE.
  - Both are unsigned modulo 2^CNT_W: all-ones wraps to 0.
  - Neither counts in HOLD.
- With `i_ex_valid=0`, all EX inputs are don't-care.

## Timing
- Redirect and flush have zero latency in IDLE (combinational from EX inputs).
- In HOLD, the outputs come from registers.
- HOLD lasts N cycles, where N ≥ 1 is the number of consecutive `i_imem_ready=0` cycles.
- Counters update on the edge that ends the qualifying cycle and are visible the next cycle.
- Reset: state=IDLE, `tgt_q=0`, counters=0, `o_misaligned=0`.
  - All combinational outputs are therefore 0 while `i_rst_n=0` with `i_ex_valid=0`.
  - While `i_rst_n=0`, `redirect_req` is masked, so all outputs are 0 regardless of the EX inputs.
- Reset asserted during HOLD: next cycle is IDLE, `o_redirect_pending=0` and the pending target is discarded.
- Back-to-back taken branches cannot occur, because the second is flushed.
- A taken branch on the cycle HOLD exits is ignored, since it is a bubble.

## Structure
- Shared package `branch_ctrl_pkg`: state enum `br_state_e {BR_IDLE, BR_HOLD}`, `XLEN` and `CNT_W` defaults.
- Sub-module `event_counter`, instantiated twice.
  - Parameter `W`.
  - Ports `i_clk`, `i_rst_n`, `i_inc`, `o_count`.
  - Synchronous active-low clear, wrap-around increment.

## Test plan
- **Taken BEQ, fetch ready:** `i_ex_valid=1`, `i_ex_is_branch=1`, `i_ex_taken=1`, target `0x0000_0100`, `i_imem_ready=1` → same cycle `o_pc_sel=1`, redirect `0x100`, both flushes 1; next cycle `o_br_count=1`, `o_taken_count=1`, state IDLE.
- **Taken JAL, fetch not ready:** target `0x0000_2000`, `i_imem_ready=0` for 3 cycles then 1 → `o_redirect_pending=1` for 3 cycles and `o_pc_redirect=0x2000` for 4 cycles; `o_taken_count` increments exactly once.
- **Stall/flush collision:** `i_hz_stall=1` with a taken branch → `o_stall_ifid=0`, flushes 1. Then `i_hz_stall=1` with a not-taken branch → `o_stall_ifid=1`, `o_br_count`+1, `o_taken_count` unchanged.
- **Misaligned target:** taken, target `0x0000_0102` → redirect `0x102`, and `o_misaligned=1` for exactly one cycle, on the following cycle.
- **Reset mid-HOLD:** enter HOLD, assert `i_rst_n=0` for one cycle → next cycle `o_redirect_pending=0`, `o_pc_sel=0`, counters 0.
- **Counter wrap (CNT_W=4):** 16 not-taken branches → `o_br_count` reads 15 then 0; `o_taken_count` stays 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch redirect controller.
//   br_state_e    : redirect FSM states (IDLE = normal fetch, HOLD = redirect
//                   waiting for fetch to accept it)
//   DEFAULT_XLEN  : default PC/target width
//   DEFAULT_CNT_W : default performance counter width
package branch_ctrl_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic {
        BR_IDLE = 1'b0,
        BR_HOLD = 1'b1
    } br_state_e;

endpackage : branch_ctrl_pkg

// File: rtl/event_counter.sv
// Wrap-around event counter.
// Ports:
//   i_clk    : clock, state on rising edge
//   i_rst_n  : synchronous active-low clear
//   i_inc    : count one event this cycle
//   o_count  : current count, unsigned modulo 2^W
module event_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_inc) begin
            // All-ones rolls over to zero naturally.
            count_q <= count_q + W'(1);
        end
    end

    assign o_count = count_q;

endmodule : event_counter

// File: rtl/branch_redirect_ctrl.sv
// Control-flow redirect sequencer for the 5-stage pipeline.
// Takes the EX-stage branch/JAL decision, drives the fetch PC mux and the
// IF/ID and ID/EX flushes, holds a redirect until fetch accepts it, lets a
// flush override a load-use stall, and keeps branch performance counters.
// Ports:
//   i_clk, i_rst_n         : clock and synchronous active-low reset
//   i_ex_valid             : EX holds a real instruction
//   i_ex_is_branch/_is_jal : EX instruction class
//   i_ex_taken             : taken decision (includes JAL)
//   i_ex_target            : computed target
//   i_hz_stall             : load-use stall request
//   i_imem_ready           : fetch accepts a new PC this cycle
//   o_pc_sel/o_pc_redirect : fetch PC mux select and redirect address
//   o_flush_ifid/_idex     : squash wrong-path instructions
//   o_stall_ifid           : hold PC and IF/ID
//   o_redirect_pending     : FSM is in HOLD
//   o_misaligned           : one-cycle pulse after a misaligned target is accepted
//   o_br_count/o_taken_count : branch and taken-redirect event counters
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_branch,
    input  logic             i_ex_is_jal,
    input  logic             i_ex_taken,
    input  logic [XLEN-1:0]  i_ex_target,
    input  logic             i_hz_stall,
    input  logic             i_imem_ready,
    output logic             o_pc_sel,
    output logic [XLEN-1:0]  o_pc_redirect,
    output logic             o_flush_ifid,
    output logic             o_flush_idex,
    output logic             o_stall_ifid,
    output logic             o_redirect_pending,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_taken_count
);

    br_state_e       state_q, state_d;
    logic [XLEN-1:0] tgt_q;
    logic            misaligned_q;
    logic            redirect_req;
    logic            idle_accept;
    logic            br_inc;
    logic            taken_inc;

    // Reset masks the request so nothing leaks out while the pipe is clearing.
    assign redirect_req = i_rst_n & i_ex_valid & i_ex_taken;
    assign idle_accept  = (state_q == BR_IDLE) & redirect_req;

    // EX inputs are bubbles during HOLD, so counting is restricted to IDLE.
    assign br_inc    = (state_q == BR_IDLE) & i_rst_n & i_ex_valid &
                       (i_ex_is_branch | i_ex_is_jal);
    assign taken_inc = idle_accept;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= BR_IDLE;
            tgt_q        <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= idle_accept & (|i_ex_target[1:0]);
            if (idle_accept && !i_imem_ready) begin
                tgt_q <= i_ex_target;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        o_pc_sel           = 1'b0;
        o_pc_redirect      = '0;
        o_flush_ifid       = 1'b0;
        o_flush_idex       = 1'b0;
        o_redirect_pending = 1'b0;
        unique case (state_q)
            BR_IDLE: begin
                if (redirect_req) begin
                    o_pc_sel      = 1'b1;
                    o_pc_redirect = i_ex_target;
                    o_flush_ifid  = 1'b1;
                    o_flush_idex  = 1'b1;
                    if (!i_imem_ready) begin
                        state_d = BR_HOLD;
                    end
                end
            end
            BR_HOLD: begin
                // The exit cycle still presents the held target.
                if (i_rst_n) begin
                    o_pc_sel           = 1'b1;
                    o_pc_redirect      = tgt_q;
                    o_flush_ifid       = 1'b1;
                    o_flush_idex       = 1'b1;
                    o_redirect_pending = 1'b1;
                end
                if (i_imem_ready) begin
                    state_d = BR_IDLE;
                end
            end
            default: state_d = BR_IDLE;
        endcase
    end

    // A stall coincident with a flush belongs to a wrong-path instruction.
    assign o_stall_ifid = i_hz_stall & ~o_flush_ifid;
    assign o_misaligned = misaligned_q;

    event_counter #(.W(CNT_W)) u_br_count (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (br_inc),
        .o_count (o_br_count)
    );

    event_counter #(.W(CNT_W)) u_taken_count (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (taken_inc),
        .o_count (o_taken_count)
    );

endmodule : branch_redirect_ctrl

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ex_valid, ex_is_branch, ex_is_jal, ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic             hz_stall, imem_ready;
    logic             pc_sel;
    logic [XLEN-1:0]  pc_redirect;
    logic             flush_ifid, flush_idex, stall_ifid;
    logic             redirect_pending, misaligned;
    logic [CNT_W-1:0] br_count, taken_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_ex_valid         (ex_valid),
        .i_ex_is_branch     (ex_is_branch),
        .i_ex_is_jal        (ex_is_jal),
        .i_ex_taken         (ex_taken),
        .i_ex_target        (ex_target),
        .i_hz_stall         (hz_stall),
        .i_imem_ready       (imem_ready),
        .o_pc_sel           (pc_sel),
        .o_pc_redirect      (pc_redirect),
        .o_flush_ifid       (flush_ifid),
        .o_flush_idex       (flush_idex),
        .o_stall_ifid       (stall_ifid),
        .o_redirect_pending (redirect_pending),
        .o_misaligned       (misaligned),
        .o_br_count         (br_count),
        .o_taken_count      (taken_count)
    );

    // One cycle of stimulus plus the outputs expected during that cycle.
    // Registered outputs (misaligned, counters) reflect earlier cycles.
    typedef struct packed {
        logic             rst_n, valid, br, jal, taken;
        logic [XLEN-1:0]  tgt;
        logic             hz, rdy;
        logic             e_sel;
        logic [XLEN-1:0]  e_red;
        logic             e_fl, e_st, e_pend, e_mis;
        logic [CNT_W-1:0] e_br, e_tk;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[15];

    function automatic vec_t mk(logic r, logic v, logic b, logic j, logic t,
                                logic [XLEN-1:0] tg, logic hz, logic rdy,
                                logic sel, logic [XLEN-1:0] red, logic fl,
                                logic st, logic pend, logic mis,
                                logic [CNT_W-1:0] cb, logic [CNT_W-1:0] ct);
        vec_t x;
        x.rst_n = r; x.valid = v; x.br = b; x.jal = j; x.taken = t;
        x.tgt = tg; x.hz = hz; x.rdy = rdy;
        x.e_sel = sel; x.e_red = red; x.e_fl = fl; x.e_st = st;
        x.e_pend = pend; x.e_mis = mis; x.e_br = cb; x.e_tk = ct;
        return x;
    endfunction

    task automatic check(input string nm, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst_n        = v.rst_n;
        ex_valid     = v.valid;
        ex_is_branch = v.br;
        ex_is_jal    = v.jal;
        ex_taken     = v.taken;
        ex_target    = v.tgt;
        hz_stall     = v.hz;
        imem_ready   = v.rdy;
    endtask

    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, ".pc_sel"},     XLEN'(pc_sel),           XLEN'(e.e_sel));
        check({tag, ".redirect"},   pc_redirect,             e.e_red);
        check({tag, ".flush_ifid"}, XLEN'(flush_ifid),       XLEN'(e.e_fl));
        check({tag, ".flush_idex"}, XLEN'(flush_idex),       XLEN'(e.e_fl));
        check({tag, ".stall"},      XLEN'(stall_ifid),       XLEN'(e.e_st));
        check({tag, ".pending"},    XLEN'(redirect_pending), XLEN'(e.e_pend));
        check({tag, ".misaligned"}, XLEN'(misaligned),       XLEN'(e.e_mis));
        check({tag, ".br_count"},   XLEN'(br_count),         XLEN'(e.e_br));
        check({tag, ".taken_cnt"},  XLEN'(taken_count),      XLEN'(e.e_tk));
    endtask

    initial begin
        vec_t nop;
        rst_n = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0;
        ex_taken = 1'b0; ex_target = '0; hz_stall = 1'b0; imem_ready = 1'b1;

        //          rst v  b  j  t  target        hz rdy sel redirect      fl st pd ms br tk
        tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 1, 32'h100,      0, 1,  1, 32'h100,      1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 1, 1);
        tbl[3]  = mk(1, 1, 0, 1, 1, 32'h2000,     0, 0,  1, 32'h2000,     1, 0, 0, 0, 1, 1);
        tbl[4]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 0,  1, 32'h2000,     1, 0, 1, 0, 2, 2);
        tbl[5]  = mk(1, 1, 1, 0, 1, 32'h5555,     1, 0,  1, 32'h2000,     1, 0, 1, 0, 2, 2);
        tbl[6]  = mk(1, 1, 1, 0, 1, 32'h3000,     0, 1,  1, 32'h2000,     1, 0, 1, 0, 2, 2);
        tbl[7]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 2, 2);
        tbl[8]  = mk(1, 1, 1, 0, 1, 32'h40,       1, 1,  1, 32'h40,       1, 0, 0, 0, 2, 2);
        tbl[9]  = mk(1, 1, 1, 0, 0, 32'h80,       1, 1,  0, 32'h0,        0, 1, 0, 0, 3, 3);
        tbl[10] = mk(1, 1, 1, 0, 1, 32'h102,      0, 1,  1, 32'h102,      1, 0, 0, 0, 4, 3);
        tbl[11] = mk(1, 0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 1, 5, 4);
        tbl[12] = mk(1, 0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 5, 4);
        tbl[13] = mk(1, 1, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 5, 4);
        tbl[14] = mk(1, 0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 5, 4);

        nop = mk(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        drive(nop);
        drive(nop);
        // Reset masks a taken EX instruction completely.
        apply("reset_masked", mk(0, 1, 1, 0, 1, 32'h100, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset while a redirect is held: target discarded, counters cleared.
        apply("rst_hold_enter", mk(1, 1, 1, 0, 1, 32'h80, 0, 0, 1, 32'h80, 1, 0, 0, 0, 5, 4));
        drive(mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        apply("rst_hold_after", mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        apply("rst_hold_new",   mk(1, 1, 0, 1, 1, 32'h200, 0, 1, 1, 32'h200, 1, 0, 0, 0, 0, 0));

        // Counter wrap: 16 not-taken branches on a 4-bit counter.
        drive(nop);
        for (int i = 0; i < 16; i++) begin
            apply($sformatf("wrap%0d", i),
                  mk(1, 1, 1, 0, 0, 32'h44, 0, 1, 0, 32'h0, 0, 0, 0, 0, CNT_W'(i), 0));
        end
        apply("wrap_zero", mk(1, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_branch_redirect_ctrl
